// File: rtl/mm_cmd_initiator.sv
// Register-bus initiator: takes one host command at a time, issues a single-cycle
// MM read or write strobe, and returns read data, a write ack, or a read-timeout error.
module mm_cmd_initiator #(
  parameter int ADDR_W  = 17,
  parameter int DATA_W  = 64,
  parameter int TIMEOUT = 64,
  parameter logic [DATA_W-1:0] TO_DATA = DATA_W'(64'hDEAD_BEEF_0BAD_0BAD)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              iCMD_V,
  output logic              oCMD_RDY,
  input  logic              iCMD_WR,
  input  logic [ADDR_W-1:0] iCMD_ADDR,
  input  logic [DATA_W-1:0] iCMD_WDATA,
  output logic              oRSP_V,
  input  logic              iRSP_RDY,
  output logic [DATA_W-1:0] oRSP_DATA,
  output logic              oRSP_ERR,
  output logic              oRSP_WR,
  output logic              oMM_WR_EN,
  output logic              oMM_RD_EN,
  output logic [ADDR_W-1:0] oMM_ADDR,
  output logic [DATA_W-1:0] oMM_WR_DATA,
  input  logic [DATA_W-1:0] iMM_RD_DATA,
  input  logic              iMM_RD_DATA_V,
  output logic [15:0]       oTO_CNT,
  output logic [15:0]       oSTRAY_CNT
);

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT_RD, RESP} state_t;

  localparam logic [15:0] LAST_WAIT = 16'(TIMEOUT - 1);
  localparam logic [15:0] CNT_MAX   = 16'hFFFF;

  state_t      state;
  logic        cmd_wr;
  logic [15:0] wait_cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      cmd_wr      <= 1'b0;
      wait_cnt    <= '0;
      oCMD_RDY    <= 1'b0;
      oRSP_V      <= 1'b0;
      oRSP_DATA   <= '0;
      oRSP_ERR    <= 1'b0;
      oRSP_WR     <= 1'b0;
      oMM_WR_EN   <= 1'b0;
      oMM_RD_EN   <= 1'b0;
      oMM_ADDR    <= '0;
      oMM_WR_DATA <= '0;
      oTO_CNT     <= '0;
    end else begin
      oMM_WR_EN <= 1'b0;
      oMM_RD_EN <= 1'b0;
      case (state)
        IDLE: begin
          if (oCMD_RDY && iCMD_V) begin
            // Address/data are loaded here so they are on the bus during ISSUE
            // and stay there until the next command is issued.
            oCMD_RDY    <= 1'b0;
            cmd_wr      <= iCMD_WR;
            oMM_ADDR    <= iCMD_ADDR;
            oMM_WR_DATA <= iCMD_WDATA;
            oMM_WR_EN   <= iCMD_WR;
            oMM_RD_EN   <= !iCMD_WR;
            state       <= ISSUE;
          end else begin
            oCMD_RDY <= 1'b1;
          end
        end
        ISSUE: begin
          wait_cnt <= '0;
          if (cmd_wr) begin
            oRSP_V    <= 1'b1;
            oRSP_WR   <= 1'b1;
            oRSP_DATA <= '0;
            oRSP_ERR  <= 1'b0;
            state     <= RESP;
          end else begin
            state <= WAIT_RD;
          end
        end
        WAIT_RD: begin
          // A return on the final wait cycle still beats the timeout.
          if (iMM_RD_DATA_V) begin
            oRSP_V    <= 1'b1;
            oRSP_WR   <= 1'b0;
            oRSP_DATA <= iMM_RD_DATA;
            oRSP_ERR  <= 1'b0;
            state     <= RESP;
          end else if (wait_cnt == LAST_WAIT) begin
            oRSP_V    <= 1'b1;
            oRSP_WR   <= 1'b0;
            oRSP_DATA <= TO_DATA;
            oRSP_ERR  <= 1'b1;
            if (oTO_CNT != CNT_MAX) begin
              oTO_CNT <= oTO_CNT + 16'd1;
            end
            state <= RESP;
          end else begin
            wait_cnt <= wait_cnt + 16'd1;
          end
        end
        RESP: begin
          if (iRSP_RDY) begin
            oRSP_V   <= 1'b0;
            oCMD_RDY <= 1'b1;
            state    <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Any read return outside WAIT_RD (including late ones after a timeout) is stray.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      oSTRAY_CNT <= '0;
    end else if (iMM_RD_DATA_V && (state != WAIT_RD) && (oSTRAY_CNT != CNT_MAX)) begin
      oSTRAY_CNT <= oSTRAY_CNT + 16'd1;
    end
  end

endmodule

// File: tb/tb_mm_cmd_initiator.sv
// Bench for mm_cmd_initiator: a cycle-timeline model (acceptance time + fixed offsets)
// is checked against the DUT every cycle, plus directed literal checks and random traffic.
module tb_mm_cmd_initiator;

  localparam int TMO = 64;
  localparam logic [63:0] TO_DATA_EXP = 64'hDEAD_BEEF_0BAD_0BAD;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        iCMD_V = 1'b0;
  logic        oCMD_RDY;
  logic        iCMD_WR = 1'b0;
  logic [16:0] iCMD_ADDR = '0;
  logic [63:0] iCMD_WDATA = '0;
  logic        oRSP_V;
  logic        iRSP_RDY = 1'b1;
  logic [63:0] oRSP_DATA;
  logic        oRSP_ERR;
  logic        oRSP_WR;
  logic        oMM_WR_EN;
  logic        oMM_RD_EN;
  logic [16:0] oMM_ADDR;
  logic [63:0] oMM_WR_DATA;
  logic [63:0] iMM_RD_DATA = '0;
  logic        iMM_RD_DATA_V = 1'b0;
  logic [15:0] oTO_CNT;
  logic [15:0] oSTRAY_CNT;

  mm_cmd_initiator #(.ADDR_W(17), .DATA_W(64), .TIMEOUT(TMO)) dut (
    .clk(clk), .rst_n(rst_n),
    .iCMD_V(iCMD_V), .oCMD_RDY(oCMD_RDY), .iCMD_WR(iCMD_WR),
    .iCMD_ADDR(iCMD_ADDR), .iCMD_WDATA(iCMD_WDATA),
    .oRSP_V(oRSP_V), .iRSP_RDY(iRSP_RDY), .oRSP_DATA(oRSP_DATA),
    .oRSP_ERR(oRSP_ERR), .oRSP_WR(oRSP_WR),
    .oMM_WR_EN(oMM_WR_EN), .oMM_RD_EN(oMM_RD_EN), .oMM_ADDR(oMM_ADDR),
    .oMM_WR_DATA(oMM_WR_DATA), .iMM_RD_DATA(iMM_RD_DATA),
    .iMM_RD_DATA_V(iMM_RD_DATA_V), .oTO_CNT(oTO_CNT), .oSTRAY_CNT(oSTRAY_CNT)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;
  int cyc = 0;
  int n_strobe = 0;

  // Model: one command in flight, described by its acceptance cycle t_acc.
  // Strobe at t_acc+1, write ack valid at t_acc+2, read window t_acc+2 .. t_acc+1+TMO.
  bit          busy;
  int          t_acc;
  bit          m_is_wr;
  bit          m_rdy;
  logic [16:0] m_addr;
  logic [63:0] m_wdata;
  bit          m_rsp_v;
  logic [63:0] m_rsp_data;
  bit          m_rsp_err;
  bit          m_rsp_wr;
  logic [15:0] m_to;
  logic [15:0] m_stray;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      if (n_bad <= 40)
        $display("FAIL %s cyc=%0d actual=%h required=%h", nm, cyc, act, exp);
    end
  endtask

  task automatic model_reset();
    busy = 0; t_acc = 0; m_is_wr = 0; m_rdy = 0;
    m_addr = '0; m_wdata = '0; m_rsp_v = 0; m_rsp_data = '0;
    m_rsp_err = 0; m_rsp_wr = 0; m_to = '0; m_stray = '0;
  endtask

  task automatic respond(input bit wr, input logic [63:0] d, input bit err);
    m_rsp_v = 1; m_rsp_wr = wr; m_rsp_data = d; m_rsp_err = err;
  endtask

  // Advance the model across the edge that ends cycle 'cyc', using this cycle's inputs.
  task automatic model_step();
    bit waiting;
    waiting = busy && !m_is_wr && !m_rsp_v && (cyc >= t_acc + 2);
    if (iMM_RD_DATA_V && !waiting && m_stray != 16'hFFFF) m_stray++;
    if (!busy) begin
      if (m_rdy && iCMD_V) begin
        busy = 1; t_acc = cyc; m_is_wr = iCMD_WR; m_rdy = 0;
        m_addr = iCMD_ADDR; m_wdata = iCMD_WDATA;
      end else begin
        m_rdy = 1;
      end
    end else if (m_rsp_v) begin
      if (iRSP_RDY) begin busy = 0; m_rsp_v = 0; m_rdy = 1; end
    end else if (m_is_wr) begin
      if (cyc == t_acc + 1) respond(1, 64'h0, 0);
    end else if (waiting) begin
      if (iMM_RD_DATA_V) respond(0, iMM_RD_DATA, 0);
      else if (cyc == t_acc + 1 + TMO) begin
        respond(0, TO_DATA_EXP, 1);
        if (m_to != 16'hFFFF) m_to++;
      end
    end
  endtask

  task automatic compare();
    bit strobe_cyc;
    strobe_cyc = busy && (cyc == t_acc + 1);
    chk("cmd_rdy", 64'(oCMD_RDY), 64'(m_rdy));
    chk("wr_en", 64'(oMM_WR_EN), 64'(strobe_cyc && m_is_wr));
    chk("rd_en", 64'(oMM_RD_EN), 64'(strobe_cyc && !m_is_wr));
    chk("mm_addr", 64'(oMM_ADDR), 64'(m_addr));
    chk("mm_wdata", oMM_WR_DATA, m_wdata);
    chk("rsp_v", 64'(oRSP_V), 64'(m_rsp_v));
    if (m_rsp_v) begin
      chk("rsp_data", oRSP_DATA, m_rsp_data);
      chk("rsp_err", 64'(oRSP_ERR), 64'(m_rsp_err));
      chk("rsp_wr", 64'(oRSP_WR), 64'(m_rsp_wr));
    end
    chk("to_cnt", 64'(oTO_CNT), 64'(m_to));
    chk("stray_cnt", 64'(oSTRAY_CNT), 64'(m_stray));
    if (oMM_WR_EN || oMM_RD_EN) n_strobe++;
  endtask

  task automatic tick();
    if (rst_n) model_step(); else model_reset();
    @(posedge clk);
    #1;
    cyc++;
    compare();
  endtask

  // Presents a command, waits for ready (bounded), returns at cycle T+1.
  task automatic issue(input bit wr, input logic [16:0] a, input logic [63:0] d);
    int guard = 0;
    while (!oCMD_RDY && guard < 200) begin tick(); guard++; end
    chk("cmd_rdy_wait", 64'(oCMD_RDY), 64'd1);
    iCMD_V = 1; iCMD_WR = wr; iCMD_ADDR = a; iCMD_WDATA = d;
    tick();
    iCMD_V = 0;
  endtask

  bit kind_q[$];
  int n_acc, n_rsp, due, guard, strobe_base;
  logic [63:0] bp_data;

  initial begin
    model_reset();
    repeat (3) tick();
    chk("reset_cmd_rdy", 64'(oCMD_RDY), 64'd0);
    chk("reset_rsp_v", 64'(oRSP_V), 64'd0);
    rst_n = 1;
    tick();
    chk("post_reset_rdy", 64'(oCMD_RDY), 64'd1);

    // Write: strobe at T+1, ack at T+2, ready again at T+3.
    iRSP_RDY = 1;
    issue(1, 17'h04010, 64'h1122_3344_5566_7788);
    chk("t1_wr_en", 64'(oMM_WR_EN), 64'd1);
    chk("t1_rd_en", 64'(oMM_RD_EN), 64'd0);
    chk("t1_addr", 64'(oMM_ADDR), 64'h04010);
    chk("t1_wdata", oMM_WR_DATA, 64'h1122_3344_5566_7788);
    tick();
    chk("t1_wr_en_off", 64'(oMM_WR_EN), 64'd0);
    chk("t1_rsp_v", 64'(oRSP_V), 64'd1);
    chk("t1_rsp_wr", 64'(oRSP_WR), 64'd1);
    chk("t1_rsp_err", 64'(oRSP_ERR), 64'd0);
    chk("t1_rsp_data", oRSP_DATA, 64'd0);
    tick();
    chk("t1_rdy_t3", 64'(oCMD_RDY), 64'd1);
    $display("write ack addr=04010 seen");

    // Read answered at T+4, response at T+5.
    issue(0, 17'h08000, 64'h0);
    chk("t2_rd_en", 64'(oMM_RD_EN), 64'd1);
    chk("t2_wr_en", 64'(oMM_WR_EN), 64'd0);
    repeat (3) tick();
    iMM_RD_DATA_V = 1; iMM_RD_DATA = 64'hCAFE_F00D_0000_0001;
    tick();
    iMM_RD_DATA_V = 0;
    chk("t2_rsp_v", 64'(oRSP_V), 64'd1);
    chk("t2_rsp_data", oRSP_DATA, 64'hCAFE_F00D_0000_0001);
    chk("t2_rsp_err", 64'(oRSP_ERR), 64'd0);
    tick();
    $display("read addr=08000 data=cafef00d00000001");

    // Timeout at T+66, then a late return counted as stray.
    issue(0, 17'h00123, 64'h0);
    repeat (64) tick();
    chk("t3_no_rsp_t65", 64'(oRSP_V), 64'd0);
    tick();
    chk("t3_rsp_v", 64'(oRSP_V), 64'd1);
    chk("t3_rsp_err", 64'(oRSP_ERR), 64'd1);
    chk("t3_rsp_data", oRSP_DATA, TO_DATA_EXP);
    chk("t3_to_cnt", 64'(oTO_CNT), 64'd1);
    repeat (4) tick();
    iMM_RD_DATA_V = 1; iMM_RD_DATA = 64'h1;
    tick();
    iMM_RD_DATA_V = 0;
    chk("t3_stray", 64'(oSTRAY_CNT), 64'd1);
    chk("t3_no_extra_rsp", 64'(oRSP_V), 64'd0);
    $display("read addr=00123 timed out");

    // Return on the last wait cycle beats the timeout.
    issue(0, 17'h00124, 64'h0);
    repeat (64) tick();
    iMM_RD_DATA_V = 1; iMM_RD_DATA = 64'h5A5A_0000_1234_5678;
    tick();
    iMM_RD_DATA_V = 0;
    chk("t3b_rsp_v", 64'(oRSP_V), 64'd1);
    chk("t3b_rsp_err", 64'(oRSP_ERR), 64'd0);
    chk("t3b_rsp_data", oRSP_DATA, 64'h5A5A_0000_1234_5678);
    chk("t3b_to_cnt", 64'(oTO_CNT), 64'd1);
    tick();
    $display("read addr=00124 last-cycle data accepted");

    // Response backpressure for 10 cycles with ignored command pulses.
    iRSP_RDY = 0;
    issue(0, 17'h00200, 64'h0);
    tick();
    iMM_RD_DATA_V = 1; iMM_RD_DATA = 64'h0123_4567_89AB_CDEF;
    bp_data = iMM_RD_DATA;
    tick();
    iMM_RD_DATA_V = 0;
    iCMD_WR = 1; iCMD_ADDR = 17'h1FFFF; iCMD_WDATA = 64'hFFFF;
    for (int i = 0; i < 10; i++) begin
      iCMD_V = i[0];
      chk("t4_rsp_v_hold", 64'(oRSP_V), 64'd1);
      chk("t4_rsp_data_hold", oRSP_DATA, bp_data);
      chk("t4_cmd_rdy_low", 64'(oCMD_RDY), 64'd0);
      tick();
    end
    iCMD_V = 0; iRSP_RDY = 1;
    tick();
    chk("t4_rsp_done", 64'(oRSP_V), 64'd0);
    chk("t4_rdy_back", 64'(oCMD_RDY), 64'd1);
    $display("read addr=00200 held under backpressure");

    // Asynchronous reset during WAIT_RD.
    issue(0, 17'h00300, 64'h0);
    repeat (3) tick();
    rst_n = 0;
    model_reset();
    #1;
    chk("t5_rdy_zero", 64'(oCMD_RDY), 64'd0);
    chk("t5_rsp_v_zero", 64'(oRSP_V), 64'd0);
    chk("t5_addr_zero", 64'(oMM_ADDR), 64'd0);
    chk("t5_to_zero", 64'(oTO_CNT), 64'd0);
    chk("t5_stray_zero", 64'(oSTRAY_CNT), 64'd0);
    compare();
    repeat (2) tick();
    rst_n = 1;
    tick();
    chk("t5_rdy_after", 64'(oCMD_RDY), 64'd1);
    chk("t5_no_rsp", 64'(oRSP_V), 64'd0);
    repeat (5) tick();
    $display("reset mid-read abandoned command");

    // Random back-to-back traffic with a latency-randomised responder.
    n_acc = 0; n_rsp = 0; due = -1; guard = 0; strobe_base = n_strobe;
    while ((n_acc < 100 || n_rsp < n_acc) && guard < 15000) begin
      bit acc;
      guard++;
      if (oMM_RD_EN) due = cyc + $urandom_range(1, 70);
      iMM_RD_DATA_V = (cyc == due) || ($urandom_range(0, 49) == 0);
      iMM_RD_DATA = {$urandom(), $urandom()};
      iRSP_RDY = ($urandom_range(0, 3) != 0);
      if (!iCMD_V && n_acc < 100 && $urandom_range(0, 3) != 0) begin
        iCMD_V = 1; iCMD_WR = $urandom_range(0, 1) == 1;
        iCMD_ADDR = 17'($urandom()); iCMD_WDATA = {$urandom(), $urandom()};
      end
      acc = iCMD_V && oCMD_RDY;
      if (acc) begin n_acc++; kind_q.push_back(iCMD_WR); end
      if (oRSP_V && iRSP_RDY) begin
        n_rsp++;
        if (kind_q.size() > 0) chk("rsp_order", 64'(oRSP_WR), 64'(kind_q.pop_front()));
        else chk("rsp_unexpected", 64'(oRSP_V), 64'd0);
        $display("rsp %0d wr=%0b err=%0b data=%h", n_rsp, oRSP_WR, oRSP_ERR, oRSP_DATA);
      end
      tick();
      if (acc) iCMD_V = 0;
    end
    iMM_RD_DATA_V = 0; iCMD_V = 0; iRSP_RDY = 1;
    chk("rand_accepted", 64'(n_acc), 64'd100);
    chk("rand_responses", 64'(n_rsp), 64'd100);
    chk("rand_strobes", 64'(n_strobe - strobe_base), 64'd100);
    tick();

    // Stray-count saturation.
    iMM_RD_DATA_V = 1;
    repeat (65540) tick();
    iMM_RD_DATA_V = 0;
    chk("stray_saturated", 64'(oSTRAY_CNT), 64'hFFFF);
    tick();
    chk("stray_held", 64'(oSTRAY_CNT), 64'hFFFF);
    $display("stray counter saturation done");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
